// File: rtl/uart_ram_loader_pkg.sv
// Shared types and constants for the UART-to-RAM loader.
package uart_ram_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStatAr,
    StStatR,
    StRxAr,
    StRxR,
    StWr,
    StWrB
  } state_e;

  localparam logic [7:0]  RxFifoOffset = 8'h00;
  localparam logic [7:0]  StatOffset   = 8'h08;
  localparam int unsigned RxValidBit   = 0;
  localparam logic [1:0]  RespOkay     = 2'b00;

endpackage

// File: rtl/uart_ram_loader.sv
// Polls a UART over AXI4-lite, packs received bytes into 32-bit words and writes them to RAM.
module uart_ram_loader
  import uart_ram_loader_pkg::*;
#(
  parameter int unsigned UART_ADDR_WIDTH = 4,
  parameter int unsigned RAM_ADDR_WIDTH  = 16,
  parameter int unsigned LEN_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       start,
  input  logic [LEN_WIDTH-1:0]       length,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [UART_ADDR_WIDTH-1:0] m_uart_araddr,
  output logic                       m_uart_arvalid,
  input  logic                       m_uart_arready,
  input  logic [31:0]                m_uart_rdata,
  input  logic [1:0]                 m_uart_rresp,
  input  logic                       m_uart_rvalid,
  output logic                       m_uart_rready,
  output logic [RAM_ADDR_WIDTH-1:0]  m_ram_awaddr,
  output logic                       m_ram_awvalid,
  input  logic                       m_ram_awready,
  output logic [31:0]                m_ram_wdata,
  output logic [3:0]                 m_ram_wstrb,
  output logic                       m_ram_wvalid,
  input  logic                       m_ram_wready,
  input  logic [1:0]                 m_ram_bresp,
  input  logic                       m_ram_bvalid,
  output logic                       m_ram_bready
);

  state_e                    state_q, state_d;
  logic [LEN_WIDTH-1:0]      len_q, len_d;
  logic [LEN_WIDTH-1:0]      count_q, count_d;
  logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]               pack_q, pack_d;
  logic [3:0]                strb_q, strb_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic                      done_q, done_d;
  logic                      error_q, error_d;
  logic [1:0]                lane;

  assign lane = count_q[1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      len_q     <= '0;
      count_q   <= '0;
      addr_q    <= '0;
      pack_q    <= '0;
      strb_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      pack_q    <= pack_d;
      strb_q    <= strb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    count_d   = count_q;
    addr_d    = addr_q;
    pack_d    = pack_q;
    strb_d    = strb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    done_d    = 1'b0;
    error_d   = error_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          len_d   = length;
          count_d = '0;
          addr_d  = '0;
          pack_d  = '0;
          strb_d  = '0;
          error_d = 1'b0;
          if (length == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = StStatAr;
          end
        end
      end
      StStatAr: begin
        if (m_uart_arready) state_d = StStatR;
      end
      StStatR: begin
        if (m_uart_rvalid) begin
          if (m_uart_rresp != RespOkay) begin
            error_d = 1'b1;
            done_d  = 1'b1;
            state_d = StIdle;
          end else if (m_uart_rdata[RxValidBit]) begin
            state_d = StRxAr;
          end else begin
            state_d = StStatAr;
          end
        end
      end
      StRxAr: begin
        if (m_uart_arready) state_d = StRxR;
      end
      StRxR: begin
        if (m_uart_rvalid) begin
          if (m_uart_rresp != RespOkay) begin
            error_d = 1'b1;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            pack_d[{lane, 3'b000} +: 8] = m_uart_rdata[7:0];
            strb_d[lane]                = 1'b1;
            count_d                     = count_q + 1'b1;
            if (lane == 2'd3 || count_d == len_q) begin
              state_d = StWr;
            end else begin
              state_d = StStatAr;
            end
          end
        end
      end
      StWr: begin
        // Each channel retires on its own handshake; VALID is driven from these flags only.
        aw_done_d = aw_done_q | m_ram_awready;
        w_done_d  = w_done_q | m_ram_wready;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = StWrB;
        end
      end
      StWrB: begin
        if (m_ram_bvalid) begin
          if (m_ram_bresp != RespOkay) begin
            error_d = 1'b1;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            addr_d = addr_q + RAM_ADDR_WIDTH'(4);
            pack_d = '0;
            strb_d = '0;
            if (count_q == len_q) begin
              done_d  = 1'b1;
              state_d = StIdle;
            end else begin
              state_d = StStatAr;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy  = (state_q != StIdle);
  assign done  = done_q;
  assign error = error_q;

  assign m_uart_arvalid = (state_q == StStatAr) || (state_q == StRxAr);
  assign m_uart_araddr  = (state_q == StStatAr) ? UART_ADDR_WIDTH'(StatOffset)
                                                : UART_ADDR_WIDTH'(RxFifoOffset);
  assign m_uart_rready  = (state_q == StStatR) || (state_q == StRxR);

  assign m_ram_awvalid = (state_q == StWr) && !aw_done_q;
  assign m_ram_wvalid  = (state_q == StWr) && !w_done_q;
  assign m_ram_awaddr  = addr_q;
  assign m_ram_wdata   = pack_q;
  assign m_ram_wstrb   = strb_q;
  assign m_ram_bready  = (state_q == StWrB);

  logic unused_rdata;
  assign unused_rdata = ^m_uart_rdata[31:8];

endmodule

// File: doc/uart_ram_loader.md
UART_RAM_LOADER -- requirements
Module: uart_ram_loader

Interface
REQ-001 SHALL have parameter UART_ADDR_WIDTH, default 4, meaning the AXI4-lite address width of the UART slave.
REQ-002 SHALL have parameter RAM_ADDR_WIDTH, default 16, meaning the AXI4-lite byte-address width of the RAM slave.
REQ-003 SHALL have parameter LEN_WIDTH, default 16, meaning the width of the byte-count input.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle load request; ignored while busy.
REQ-007 SHALL have port length  input  LEN_WIDTH  number of bytes to load; sampled on the accepted start.
REQ-008 SHALL have port busy / done / error  output  1 each  busy = in progress; done = one-cycle completion pulse; error = sticky fault flag.
REQ-009 SHALL have UART read-master ports m_uart_araddr (UART_ADDR_WIDTH), m_uart_arvalid, m_uart_arready, m_uart_rdata (32), m_uart_rresp (2), m_uart_rvalid, m_uart_rready, with AXI4-lite directions.
REQ-010 SHALL have RAM write-master ports m_ram_awaddr (RAM_ADDR_WIDTH), m_ram_awvalid, m_ram_awready, m_ram_wdata (32), m_ram_wstrb (4), m_ram_wvalid, m_ram_wready, m_ram_bresp (2), m_ram_bvalid, m_ram_bready, with AXI4-lite directions.

Function
REQ-011 SHALL implement states IDLE, STAT_AR, STAT_R, RX_AR, RX_R, WR, WR_B.
REQ-012 IDLE + start: SHALL latch length, clear the byte counter, word address and error, and go to STAT_AR; if length==0, SHALL stay in IDLE and pulse done the next cycle.
REQ-013 STAT_AR: SHALL drive araddr=0x8 (status) with arvalid high until arready, then go to STAT_R.
REQ-014 STAT_R: SHALL hold rready high; on rvalid, if rdata[0]==1 (RX valid) go to RX_AR, else return to STAT_AR (re-poll).
REQ-015 RX_AR / RX_R: SHALL read address 0x0 (RX FIFO) and store rdata[7:0] into byte lane (count mod 4) of the pack register, then increment count.
REQ-016 After a byte is stored: SHALL go to WR if the lane was 3 or count==length; otherwise go to STAT_AR.
REQ-017 WR: SHALL assert awvalid and wvalid together with awaddr=word address and wdata=pack register.
REQ-018 wstrb SHALL be 4'b1111 for full words, and only the filled lanes (LSB-first) for the final partial word.
REQ-019 Each of awvalid and wvalid SHALL drop independently after its own handshake; both handshakes complete before WR_B.
REQ-020 WR_B: SHALL hold bready high; on bvalid, advance word address by 4 (wrapping modulo 2^RAM_ADDR_WIDTH) and clear the pack register.
REQ-021 On the final write's bvalid: SHALL return to IDLE and pulse done; otherwise go to STAT_AR.
REQ-022 Any rresp≠0 or bresp≠0 SHALL set error, abort to IDLE and pulse done; no further transactions are issued.
REQ-023 busy SHALL be high in every state except IDLE.
REQ-024 VALID SHALL never depend combinationally on READY, and address/data SHALL be stable while VALID is high and unacknowledged.
REQ-025 start asserted while busy SHALL have no effect.

Reset
REQ-026 resetn low SHALL immediately force IDLE and deassert every valid/ready, busy, done and error; all address, data and counter registers SHALL be 0.
REQ-027 Reset mid-transaction SHALL abandon the transaction without completing any pending handshake.

Structure
REQ-028 A shared package SHALL hold the state enum, UART register offsets (RX_FIFO=0x0, STAT=0x8), the RX-valid bit index, and OKAY=2'b00.
REQ-029 The block SHALL be a single module with no sub-modules; the UART and RAM SHALL connect directly to the two master ports.

Verification
REQ-030 Length 4, bytes 0x11,0x22,0x33,0x44 available -> exactly one RAM write to address 0x0 with wdata=0x44332211, wstrb=0xF, then done.
REQ-031 Length 6 -> writes 0x44332211 @0x0 (wstrb 0xF) and 0x00006655 @0x4 (wstrb 0x3), then done with error=0.
REQ-032 Status returns bit0=0 for 5 polls before data arrives -> 5 extra STAT_AR/STAT_R round trips and no RX FIFO read until bit0=1.
REQ-033 awready delayed 3 cycles and wready immediate -> wvalid drops after 1 cycle, awvalid holds 3 cycles, exactly one write.
REQ-034 bresp=2'b10 on the first write -> error=1, done pulse, no further AR/AW issued.
REQ-035 resetn pulsed during WR -> all outputs 0 immediately; a new start with length 1 -> single write with wstrb=0x1.
